// File: rtl/sprite_pos_ctrl_pkg.sv
// Shared definitions for the sprite position controller: VGA geometry,
// FSM state encoding, the button bundle type and the coordinate clamp helper.
package sprite_pos_ctrl_pkg;

  localparam int H_ACTIVE_C    = 640;
  localparam int V_ACTIVE_C    = 480;
  localparam int H_TOTAL_C     = 800;
  localparam int V_TOTAL_C     = 525;
  localparam int SPRITE_SIZE_C = 8;

  localparam logic [3:0] HOLD_MAX_C = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_MOVE_X,
    ST_MOVE_Y,
    ST_COMMIT
  } state_e;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } btn_t;

  function automatic logic [9:0] clamp_coord(input logic signed [10:0] v,
                                             input logic signed [10:0] hi);
    logic [9:0] r;
    if (v < 11'sd0) begin
      r = '0;
    end else if (v > hi) begin
      r = hi[9:0];
    end else begin
      r = v[9:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for asynchronous level inputs; output lags input by
// two clk_i edges and clears on reset.
module btn_sync #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sprite_pos_ctrl.sv
// Per-frame sprite position update: a frame_tick starts a 4-cycle update whose
// result appears together with pos_valid in COMMIT; ticks arriving while busy set overrun.
module sprite_pos_ctrl
  import sprite_pos_ctrl_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_C,
  parameter int V_ACTIVE = V_ACTIVE_C,
  parameter int SPRITE_W = SPRITE_SIZE_C,
  parameter int SPRITE_H = SPRITE_SIZE_C,
  parameter int X_INIT   = 316,
  parameter int Y_INIT   = 236
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       frame_tick_i,
  input  logic       btn_up_i,
  input  logic       btn_down_i,
  input  logic       btn_left_i,
  input  logic       btn_right_i,
  input  logic [3:0] step_i,
  output logic [9:0] pos_x_o,
  output logic [9:0] pos_y_o,
  output logic       pos_valid_o,
  output logic       busy_o,
  output logic       overrun_o
);

  localparam logic signed [10:0] X_MAX = 11'(H_ACTIVE - SPRITE_W);
  localparam logic signed [10:0] Y_MAX = 11'(V_ACTIVE - SPRITE_H);

  btn_t btn_s;

  btn_sync #(.W(4)) u_btn_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   ({btn_up_i, btn_down_i, btn_left_i, btn_right_i}),
    .q_o   (btn_s)
  );

  state_e     state_q, state_d;
  btn_t       dir_q, dir_d, dir_new;
  logic [3:0] hold_q, hold_d;
  logic [4:0] eff_q, eff_d;
  logic [9:0] nx_q, nx_d;
  logic [9:0] pos_x_q, pos_x_d;
  logic [9:0] pos_y_q, pos_y_d;
  logic       overrun_q, overrun_d;
  logic       dir_same, dir_empty;

  logic signed [10:0] eff_s, delta_x, delta_y, sum_x, sum_y;

  // Opposing buttons cancel, so the latched set is the net direction per axis.
  assign dir_new.up    = btn_s.up & ~btn_s.down;
  assign dir_new.down  = btn_s.down & ~btn_s.up;
  assign dir_new.left  = btn_s.left & ~btn_s.right;
  assign dir_new.right = btn_s.right & ~btn_s.left;
  assign dir_same      = (dir_new == dir_q);
  assign dir_empty     = (dir_new == '0);

  assign eff_s   = signed'({6'b0, eff_q});
  assign delta_x = dir_q.right ? eff_s : (dir_q.left ? -eff_s : 11'sd0);
  assign delta_y = dir_q.down  ? eff_s : (dir_q.up   ? -eff_s : 11'sd0);
  assign sum_x   = signed'({1'b0, pos_x_q}) + delta_x;
  assign sum_y   = signed'({1'b0, pos_y_q}) + delta_y;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (frame_tick_i) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = ST_MOVE_X;
      ST_MOVE_X: state_d = ST_MOVE_Y;
      ST_MOVE_Y: state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dir_d     = dir_q;
    hold_d    = hold_q;
    eff_d     = eff_q;
    nx_d      = nx_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    overrun_d = overrun_q | (frame_tick_i & (state_q != ST_IDLE));
    case (state_q)
      ST_SAMPLE: begin
        dir_d = dir_new;
        if (dir_empty) begin
          hold_d = '0;
        end else if (dir_same) begin
          hold_d = (hold_q == HOLD_MAX_C) ? HOLD_MAX_C : 4'(hold_q + 4'd1);
        end else begin
          hold_d = 4'd1;
        end
        // Doubling only once eight earlier frames already held this same set.
        eff_d = (!dir_empty && dir_same && hold_q == HOLD_MAX_C) ?
                {step_i, 1'b0} : {1'b0, step_i};
      end
      ST_MOVE_X: nx_d = clamp_coord(sum_x, X_MAX);
      ST_MOVE_Y: begin
        pos_x_d = nx_q;
        pos_y_d = clamp_coord(sum_y, Y_MAX);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dir_q     <= '0;
      hold_q    <= '0;
      eff_q     <= '0;
      nx_q      <= 10'(X_INIT);
      pos_x_q   <= 10'(X_INIT);
      pos_y_q   <= 10'(Y_INIT);
      overrun_q <= 1'b0;
    end else begin
      dir_q     <= dir_d;
      hold_q    <= hold_d;
      eff_q     <= eff_d;
      nx_q      <= nx_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      overrun_q <= overrun_d;
    end
  end

  assign pos_x_o     = pos_x_q;
  assign pos_y_o     = pos_y_q;
  assign pos_valid_o = (state_q == ST_COMMIT);
  assign busy_o      = (state_q != ST_IDLE);
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_sprite_pos_ctrl.sv
// Directed and randomized frames checked against a frame-level position model;
// inputs are driven and outputs sampled on the falling clock edge.
module tb_sprite_pos_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick = 1'b0;
  logic       bu = 1'b0, bd = 1'b0, bl = 1'b0, br = 1'b0;
  logic [3:0] step = 4'd0;
  logic [9:0] px, py;
  logic       pv, busy, ovr;

  int tests = 0;
  int fails = 0;

  int mx = 316, my = 236, mcnt = 0, pdx = 0, pdy = 0;

  always #20 clk = ~clk;

  sprite_pos_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .frame_tick_i(tick),
    .btn_up_i    (bu),
    .btn_down_i  (bd),
    .btn_left_i  (bl),
    .btn_right_i (br),
    .step_i      (step),
    .pos_x_o     (px),
    .pos_y_o     (py),
    .pos_valid_o (pv),
    .busy_o      (busy),
    .overrun_o   (ovr)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // One accepted frame: net direction per axis, doubling after 8 prior frames of the same set.
  function automatic void model_frame(input logic [3:0] b, input int s);
    int dx, dy, eff;
    dx  = (b[0] && !b[1]) ? 1 : ((b[1] && !b[0]) ? -1 : 0);
    dy  = (b[2] && !b[3]) ? 1 : ((b[3] && !b[2]) ? -1 : 0);
    eff = s;
    if (dx == 0 && dy == 0) begin
      mcnt = 0;
    end else if (dx == pdx && dy == pdy) begin
      if (mcnt >= 8) eff = 2 * s;
      if (mcnt < 8) mcnt++;
    end else begin
      mcnt = 1;
    end
    pdx = dx;
    pdy = dy;
    mx  = clampi(mx + dx * eff, 632);
    my  = clampi(my + dy * eff, 472);
  endfunction

  function automatic void model_reset();
    mx = 316; my = 236; mcnt = 0; pdx = 0; pdy = 0;
  endfunction

  task automatic set_inputs(input logic [3:0] b, input int s);
    bu = b[3]; bd = b[2]; bl = b[1]; br = b[0];
    step = 4'(s);
  endtask

  // b = {up, down, left, right}
  task automatic run_frame(input logic [3:0] b, input int s, input string tag);
    @(negedge clk);
    set_inputs(b, s);
    repeat (4) @(negedge clk);
    tick = 1'b1;
    model_frame(b, s);
    @(negedge clk);
    tick = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk({tag, "_busy"}, int'(busy), 1);
      chk({tag, "_pv"}, int'(pv), (k == 4) ? 1 : 0);
      if (k < 4) @(negedge clk);
    end
    chk({tag, "_x"}, int'(px), mx);
    chk({tag, "_y"}, int'(py), my);
    @(negedge clk);
    chk({tag, "_idle"}, int'(busy), 0);
    chk({tag, "_pv_end"}, int'(pv), 0);
  endtask

  initial begin
    logic [3:0] cur;
    int pv_cnt;

    #5 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_x", int'(px), 316);
    chk("rst_y", int'(py), 236);
    chk("rst_pv", int'(pv), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovr", int'(ovr), 0);
    rst_n = 1'b1;

    run_frame(4'b0000, 0, "idle_frame");
    chk("idle_pos_x", int'(px), 316);
    chk("idle_ovr", int'(ovr), 0);

    for (int i = 0; i < 10; i++) run_frame(4'b0001, 3, "right_hold");
    chk("hold_x352", int'(px), 352);
    chk("hold_y", int'(py), 236);

    for (int i = 0; i < 30 && mx < 632; i++) run_frame(4'b0001, 15, "to_right");
    run_frame(4'b0010, 1, "left1");
    run_frame(4'b0010, 1, "left1");
    chk("x_at_630", int'(px), 630);
    run_frame(4'b0001, 5, "clamp_r");
    chk("clamp_x632", int'(px), 632);
    for (int i = 0; i < 30 && my > 0; i++) run_frame(4'b1000, 15, "to_top");
    run_frame(4'b0100, 2, "down2");
    chk("y_at_2", int'(py), 2);
    run_frame(4'b1000, 5, "clamp_u");
    chk("clamp_y0", int'(py), 0);

    for (int i = 0; i < 3; i++) run_frame(4'b0011, 4, "lr_both");
    chk("lr_x", int'(px), 632);

    cur = 4'b0001;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) == 0) cur = 4'($urandom_range(15));
      run_frame(cur, int'($urandom_range(15)), "rand");
    end

    // Second tick during the update is dropped; the one right after COMMIT is taken.
    @(negedge clk);
    set_inputs(4'b0100, 3);
    repeat (4) @(negedge clk);
    pv_cnt = 0;
    tick = 1'b1;
    model_frame(4'b0100, 3);
    @(negedge clk); tick = 1'b0; pv_cnt += int'(pv);
    @(negedge clk); tick = 1'b1; pv_cnt += int'(pv);
    @(negedge clk); tick = 1'b0; pv_cnt += int'(pv);
    @(negedge clk); pv_cnt += int'(pv);
    chk("ovr_set", int'(ovr), 1);
    chk("ovr_pv_single", pv_cnt, 1);
    chk("ovr_y", int'(py), my);
    @(negedge clk);
    chk("ovr_idle", int'(busy), 0);
    tick = 1'b1;
    model_frame(4'b0100, 3);
    @(negedge clk); tick = 1'b0;
    chk("t5_busy", int'(busy), 1);
    repeat (3) @(negedge clk);
    chk("t5_pv", int'(pv), 1);
    chk("t5_y", int'(py), my);

    // Reset while in MOVE_Y must discard the pending update.
    @(negedge clk);
    set_inputs(4'b0010, 9);
    repeat (4) @(negedge clk);
    tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mrst_x", int'(px), 316);
    chk("mrst_y", int'(py), 236);
    chk("mrst_pv", int'(pv), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_ovr", int'(ovr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pv_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      pv_cnt += int'(pv);
    end
    chk("mrst_no_pv", pv_cnt, 0);
    chk("mrst_hold_x", int'(px), 316);
    run_frame(4'b0010, 9, "post_rst");

    // A tick landing in COMMIT is treated as busy.
    @(negedge clk);
    set_inputs(4'b0001, 2);
    repeat (4) @(negedge clk);
    tick = 1'b1;
    model_frame(4'b0001, 2);
    @(negedge clk); tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("commit_pv", int'(pv), 1);
    tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    chk("commit_ovr", int'(ovr), 1);
    chk("commit_ignored", int'(busy), 0);
    chk("commit_x", int'(px), mx);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sprite_pos_ctrl.md
SPRITE_POS_CTRL -- requirements
Module: sprite_pos_ctrl

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 Parameter SPRITE_W, default 8, sprite width in pixels.
REQ-004 Parameter SPRITE_H, default 8, sprite height in pixels.
REQ-005 Parameter X_INIT, default 316, reset X coordinate.
REQ-006 Parameter Y_INIT, default 236, reset Y coordinate.
REQ-007 Port clock  in  1  single 25 MHz pixel clock; all logic on rising edge.
REQ-008 Port reset  in  1  asynchronous, active-low reset.
REQ-009 Port frame_tick  in  1  one-cycle pulse at the start of vertical blanking.
REQ-010 Port btn_up, btn_down, btn_left, btn_right  in  1 each  asynchronous button levels, active-high.
REQ-011 Port step  in  4  base pixels moved per frame; 0 means no movement.
REQ-012 Port pos_x  out  10  sprite left edge, active-area coordinates.
REQ-013 Port pos_y  out  10  sprite top edge, active-area coordinates.
REQ-014 Port pos_valid  out  1  one-cycle pulse when pos_x/pos_y are updated.
REQ-015 Port busy  out  1  high while the FSM is not in IDLE.
REQ-016 Port overrun  out  1  sticky; set when frame_tick arrives while busy.

Function
REQ-017 Each button SHALL pass through a 2-flop synchronizer before use.
REQ-018 FSM states SHALL be IDLE, SAMPLE, MOVE_X, MOVE_Y, COMMIT.
REQ-019 IDLE -> SAMPLE on frame_tick; all other states SHALL advance unconditionally one state per cycle; COMMIT -> IDLE.
REQ-020 SAMPLE SHALL latch the synchronized buttons; those latched values SHALL be used for the whole update.
REQ-021 Effective step SHALL be step, or 2*step (5-bit) once the same non-zero direction set has been held for 8 or more consecutive sampled frames.
REQ-022 The hold counter SHALL saturate at 8 and SHALL clear when the latched direction set changes or becomes empty.
REQ-023 MOVE_X SHALL compute next X: right adds, left subtracts; both or neither pressed leaves X unchanged.
REQ-024 MOVE_Y SHALL compute next Y the same way: down adds, up subtracts.
REQ-025 Arithmetic SHALL use 11-bit signed intermediates; results SHALL clamp to [0, H_ACTIVE-SPRITE_W] for X and [0, V_ACTIVE-SPRITE_H] for Y.
REQ-026 pos_x/pos_y SHALL change only in COMMIT, so they stay stable during active video.
REQ-027 pos_valid SHALL pulse in the COMMIT cycle, exactly 4 cycles after the frame_tick cycle, even when the position is unchanged.
REQ-028 A frame_tick seen while busy SHALL be ignored and SHALL set overrun; overrun SHALL clear only on reset.
REQ-029 A frame_tick in the COMMIT cycle SHALL count as busy; a frame_tick in the first IDLE cycle after COMMIT SHALL be accepted.

Reset
REQ-030 On reset low: FSM=IDLE, pos_x=X_INIT, pos_y=Y_INIT, pos_valid=0, busy=0, overrun=0, hold counter=0, synchronizers=0.
REQ-031 Reset asserted mid-update SHALL abandon the update; no partial coordinate SHALL reach the outputs.
REQ-032 After reset release, the first frame_tick SHALL be processed normally.

Structure
REQ-033 The shared package SHALL hold the FSM state encoding and the VGA constants: 640/480 active area, 800/525 totals, sprite size 8.
REQ-034 One sub-module, btn_sync (2-flop synchronizer, parameterized width), SHALL be instantiated once for the 4 buttons.
REQ-035 Outputs SHALL connect directly to the pos_x/pos_y inputs of the sprite renderer with no glue logic.

Verification
REQ-036 Reset, then one frame_tick with no buttons -> pos=(316,236); pos_valid at tick+4; busy high for cycles tick+1..tick+4.
REQ-037 step=3, btn_right held, 10 frames -> X=316+3*8+6*2=352 (doubling from the 9th frame); Y unchanged.
REQ-038 pos_x=630, step=5, btn_right -> X clamps to 632; pos_y=2, step=5, btn_up -> Y clamps to 0.
REQ-039 btn_left and btn_right both held, step=4 -> X unchanged, hold counter cleared, pos_valid still pulses.
REQ-040 frame_tick at tick+2 -> ignored, overrun=1, single pos_valid; a tick at tick+5 is accepted.
REQ-041 Reset asserted in MOVE_Y -> outputs return to (316,236); no pos_valid pulse.
